// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline stages.
// Default pixel width, image dimensions and window size.
package sobel_pkg;

    localparam int PIXEL_WIDTH  = 8;
    localparam int IMAGE_WIDTH  = 640;
    localparam int IMAGE_HEIGHT = 480;
    localparam int WIN_SIZE     = 3;

endpackage

// File: rtl/line_window_3x3_line_buffer.sv
// One row of pixel storage for the 3x3 window generator.
// Single address, asynchronous read, synchronous write, no reset.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int DEPTH      = IMAGE_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Old contents stay visible until the write lands at the clock edge.
    assign rdata = mem[addr];

    // Store the incoming pixel for this column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_window_3x3.sv
// 3x3 sliding window over a raster pixel stream, no border padding.
// Define LINE_WINDOW_FRAME_DONE_EN to add the frame_done_o output.
module line_window_3x3
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int IMG_WIDTH  = IMAGE_WIDTH,
    parameter int IMG_HEIGHT = IMAGE_HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gray_i,
    input  logic                  done_i,
    output logic [DATA_WIDTH-1:0] p00_o,
    output logic [DATA_WIDTH-1:0] p01_o,
    output logic [DATA_WIDTH-1:0] p02_o,
    output logic [DATA_WIDTH-1:0] p10_o,
    output logic [DATA_WIDTH-1:0] p11_o,
    output logic [DATA_WIDTH-1:0] p12_o,
    output logic [DATA_WIDTH-1:0] p20_o,
    output logic [DATA_WIDTH-1:0] p21_o,
    output logic [DATA_WIDTH-1:0] p22_o,
`ifdef LINE_WINDOW_FRAME_DONE_EN
    output logic                  frame_done_o,
`endif
    output logic                  done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int LAST = WIN_SIZE - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_SIZE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DATA_WIDTH-1:0] lb0_q;
    logic [DATA_WIDTH-1:0] lb1_q;

    logic [DATA_WIDTH-1:0] win [WIN_SIZE][WIN_SIZE];

    logic win_ok;

    assign win_ok = (row >= ROW_FIRST) && (col >= COL_FIRST);

    // LB0 holds row r-2: it takes over LB1's old entry at this column.
    line_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_WIDTH)
    ) u_lb0 (
        .clk  (clk),
        .we   (done_i),
        .addr (col),
        .wdata(lb1_q),
        .rdata(lb0_q)
    );

    // LB1 holds row r-1: it records the incoming pixel.
    line_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_WIDTH)
    ) u_lb1 (
        .clk  (clk),
        .we   (done_i),
        .addr (col),
        .wdata(gray_i),
        .rdata(lb1_q)
    );

    // Raster position of the next pixel to arrive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (done_i) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Shift the window left and load the new right-hand column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (done_i) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < LAST; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            win[0][LAST] <= lb0_q;
            win[1][LAST] <= lb1_q;
            win[2][LAST] <= gray_i;
        end
    end

    // Flag a full window one cycle after its bottom-right pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_o <= 1'b0;
        end else begin
            done_o <= done_i && win_ok;
        end
    end

`ifdef LINE_WINDOW_FRAME_DONE_EN
    // Mark the window that ends on the last pixel of the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= done_i
                         && (row == ROW_LAST)
                         && (col == COL_LAST);
        end
    end
`endif

    assign p00_o = win[0][0];
    assign p01_o = win[0][1];
    assign p02_o = win[0][2];
    assign p10_o = win[1][0];
    assign p11_o = win[1][1];
    assign p12_o = win[1][2];
    assign p20_o = win[2][0];
    assign p21_o = win[2][1];
    assign p22_o = win[2][2];

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 on a 4x4 image.
// Expected windows come from a frame-array model of the pixel stream.
module tb_line_window_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] gray_i = '0;
    logic          done_i = 1'b0;
    logic [DW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic          done_o;
`ifdef LINE_WINDOW_FRAME_DONE_EN
    logic          frame_done_o;
`endif

    line_window_3x3 #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .gray_i(gray_i),
        .done_i(done_i),
        .p00_o (p00),
        .p01_o (p01),
        .p02_o (p02),
        .p10_o (p10),
        .p11_o (p11),
        .p12_o (p12),
        .p20_o (p20),
        .p21_o (p21),
        .p22_o (p22),
`ifdef LINE_WINDOW_FRAME_DONE_EN
        .frame_done_o(frame_done_o),
`endif
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0][DW-1:0] p;
        bit                 last;
        time                t;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] img [H][W];
    int mr = 0;
    int mc = 0;

    logic [8:0][DW-1:0] win_vec;
    assign win_vec = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, act, req);
        end
    endtask

    // Reference: place pixel in a frame image, window = 3x3 block ending here.
    task automatic model_accept(input logic [DW-1:0] v);
        exp_t e;
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    e.p[8 - (i * 3 + j)] = img[mr - 2 + i][mc - 2 + j];
                end
            end
            e.last = (mr == H - 1) && (mc == W - 1);
            e.t    = $time;
            q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr + 1) % H;
        end
    endtask

    task automatic send(input logic [DW-1:0] v, input bit valid);
        gray_i = v;
        done_i = valid;
        @(posedge clk);
        if (valid) model_accept(v);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0);
    endtask

    task automatic do_reset();
        done_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("reset_window", win_vec, '0);
        check("reset_done", done_o, 1'b0);
`ifdef LINE_WINDOW_FRAME_DONE_EN
        check("reset_frame_done", frame_done_o, 1'b0);
`endif
        mr = 0;
        mc = 0;
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done_o must match the oldest pending window, one cycle late.
    always @(negedge clk) begin
        if (rst) begin
            if (q.size() > 0 && q[0].t + 5 < $time && !done_o) begin
                check("missed_window", 1'b0, 1'b1);
                void'(q.pop_front());
            end
            if (done_o) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", 128'($time - e.t), 128'(5));
                    check("window", win_vec, e.p);
`ifdef LINE_WINDOW_FRAME_DONE_EN
                    check("frame_done", frame_done_o, e.last);
`endif
                end
            end
`ifdef LINE_WINDOW_FRAME_DONE_EN
            else if (frame_done_o) begin
                check("frame_done_without_done", 1'b1, 1'b0);
            end
`endif
        end
    end

    initial begin
        do_reset();

        for (int v = 0; v < 16; v++) send(DW'(v), 1'b1);
        idle(3);

        do_reset();
        for (int v = 0; v < 16; v++) begin
            send(DW'(v), 1'b1);
            send(DW'($urandom), 1'b0);
        end
        idle(3);

        do_reset();
        for (int v = 0; v < 32; v++) send(DW'(v), 1'b1);
        idle(3);

        do_reset();
        for (int v = 0; v <= 6; v++) send(DW'(v), 1'b1);
        do_reset();
        for (int v = 0; v < 16; v++) send(DW'(v), 1'b1);
        idle(3);

        for (int v = 0; v < 32; v++) send(8'hFF, 1'b1);
        idle(3);

        for (int v = 0; v < 3 * W * H; v++) begin
            while ($urandom_range(0, 3) == 0) send(DW'($urandom), 1'b0);
            send(DW'($urandom), 1'b1);
        end
        idle(3);

        do_reset();
        for (int v = 0; v < 9; v++) send(DW'($urandom), 1'b1);
        do_reset();
        for (int v = 0; v < 2 * W * H; v++) begin
            send(DW'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(3);

        check("queue_drained", 128'(q.size()), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, grayscale pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per row, at least 3.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, rows per frame, at least 3.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port gray_i, input, DATA_WIDTH, grayscale pixel in raster order (upstream grayscale_o).
REQ-007 SHALL have port done_i, input, 1, gray_i valid this cycle (upstream done_o).
REQ-008 SHALL have ports p00_o..p22_o, output, DATA_WIDTH each, 3x3 window; pRC = row R, column C; p00 = pixel (r-2,c-2), p22 = pixel (r,c).
REQ-009 SHALL have port done_o, output, 1, window valid this cycle.

Function
REQ-010 SHALL accept a pixel on every rising edge where done_i=1, with no back-pressure.
REQ-011 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advanced only on acceptance.
REQ-012 SHALL wrap col from IMG_WIDTH-1 to 0 and increment row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both SHALL wrap to 0 and the next pixel starts a new frame.
REQ-013 SHALL hold two line buffers of IMG_WIDTH entries: LB1 = row r-1, LB0 = row r-2.
REQ-014 SHALL, on acceptance at column c, read LB0[c] and LB1[c], then write LB0[c] <= old LB1[c] and LB1[c] <= gray_i (read-before-write).
REQ-015 SHALL shift the window one column left on acceptance and load the new right column {LB0[c], LB1[c], gray_i}.
REQ-016 SHALL pulse done_o high exactly one cycle after an accepted pixel with row>=2 and col>=2; latency 1 cycle; (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-017 SHALL NOT pad borders: no window is output for row<2 or col<2.
REQ-018 SHALL hold window outputs and state with done_o=0 during cycles where done_i=0.
REQ-019 SHALL pass pixel values through unchanged, with no arithmetic and no width change.

Reset
REQ-020 SHALL, while rst=0, force col=0, row=0, all window registers=0, done_o=0, independent of clk.
REQ-021 SHALL leave line buffer contents unreset; stale contents are never output because of REQ-016.
REQ-022 SHALL, after a mid-frame reset, treat the next accepted pixel as (0,0) of a new frame.

Configuration
REQ-023 SHALL, with macro LINE_WINDOW_FRAME_DONE_EN defined, add output frame_done_o (1 bit), high for exactly the cycle done_o carries the window whose p22 is pixel (IMG_HEIGHT-1, IMG_WIDTH-1); reset value 0.
REQ-024 SHALL, without LINE_WINDOW_FRAME_DONE_EN, omit frame_done_o and its logic entirely, with all other behaviour identical.

Structure
REQ-025 SHALL place the default DATA_WIDTH, the default image dimensions, and the window size constant (3) in shared package sobel_pkg, used by all Sobel pipeline stages.
REQ-026 SHALL implement each line buffer as sub-module line_buffer (parameters DATA_WIDTH and DEPTH; single-port address, asynchronous read, synchronous write), instantiated twice.

Verification
REQ-027 SHALL cover: 4x4 image, gray_i = 0..15 back-to-back -> 4 windows; first done_o one cycle after pixel 10, rows {0,1,2},{4,5,6},{8,9,10}; last window p22=15, p00=5.
REQ-028 SHALL cover: same image with done_i on alternate cycles -> identical 4 windows, each done_o exactly one cycle after an accepted pixel, done_o=0 in gap cycles.
REQ-029 SHALL cover: two back-to-back 4x4 frames with values 0..31 -> 8 windows; the first window of frame 2 has p00=16, p22=26.
REQ-030 SHALL cover: rst=0 asserted after pixel 6, then a fresh frame 0..15 -> done_o stays 0 until one cycle after the new pixel 10, whose window equals that of REQ-027.
REQ-031 SHALL cover: all pixels 255 -> every window element 255; with LINE_WINDOW_FRAME_DONE_EN, frame_done_o pulses once per frame, coincident with the last done_o.
